// File: rtl/hybrid_noc_router_output_if.sv
// Link bundle of the hybrid NoC router output port.
// Carries BE requests from every input, the TDM bypass and the outgoing link.
interface hybrid_noc_router_output_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int PORTS      = 5
);
   logic [PORTS*FLIT_WIDTH-1:0] in_flit;
   logic [PORTS-1:0]            in_valid;
   logic [PORTS-1:0]            in_last;
   logic [PORTS-1:0]            in_ready;
   logic [FLIT_WIDTH-1:0]       tdm_flit;
   logic                        tdm_valid;
   logic [FLIT_WIDTH-1:0]       out_flit;
   logic                        out_valid;
   logic                        out_last;
   logic                        out_tdm;
   logic                        out_ready;

   modport master (
      output in_flit, in_valid, in_last,
      output tdm_flit, tdm_valid, out_ready,
      input  in_ready, out_flit, out_valid,
      input  out_last, out_tdm
   );

   modport slave (
      input  in_flit, in_valid, in_last,
      input  tdm_flit, tdm_valid, out_ready,
      output in_ready, out_flit, out_valid,
      output out_last, out_tdm
   );
endinterface

// File: rtl/hybrid_noc_router_output.sv
// Hybrid NoC router output port: wormhole round-robin BE arbiter,
// 2-entry BE FIFO and a link mux that gives TDM beats priority.
module hybrid_noc_router_output #(
   parameter int FLIT_WIDTH = 32,
   parameter int PORTS      = 5
) (
   input logic                       clk,
   input logic                       rst,
   hybrid_noc_router_output_if.slave bus
);
   localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SW-1:0]         r_sel;
   logic [SW-1:0]         w_sel_nxt;
   logic [SW-1:0]         r_rr_ptr;
   logic [SW-1:0]         w_rr_nxt;
   logic [SW-1:0]         w_pick;
   logic [SW-1:0]         w_sel_inc;
   logic                  w_any_req;
   logic [FLIT_WIDTH-1:0] r_mem_flit [2];
   logic [1:0]            r_mem_last;
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  w_not_full;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [FLIT_WIDTH-1:0] w_sel_flit;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_be_valid;

   // first requester at or after rr_ptr, wrapping modulo PORTS
   always_comb begin
      w_pick    = r_rr_ptr;
      w_any_req = 1'b0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(r_rr_ptr) + i) % PORTS;
         if (bus.in_valid[idx]) begin
            w_pick    = SW'(idx);
            w_any_req = 1'b1;
         end
      end
   end

   assign w_sel_inc   = (r_sel == SW'(PORTS - 1)) ? '0 : r_sel + 1'b1;
   assign w_sel_valid = bus.in_valid[r_sel];
   assign w_sel_last  = bus.in_last[r_sel];
   assign w_sel_flit  = bus.in_flit[r_sel*FLIT_WIDTH +: FLIT_WIDTH];
   assign w_not_full  = (r_count != 2'd2);
   assign w_push      = (r_state == S_LOCKED) && w_sel_valid && w_not_full;
   assign w_be_valid  = (r_count != 2'd0);
   assign w_pop       = !bus.tdm_valid && w_be_valid && bus.out_ready;

   // only the locked input sees ready, and only while the FIFO has room
   always_comb begin
      bus.in_ready = '0;
      if ((r_state == S_LOCKED) && w_not_full) begin
         bus.in_ready[r_sel] = 1'b1;
      end
   end

   // arbiter next state: lock on a request, release on the pushed tail
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_rr_nxt    = r_rr_ptr;
      unique case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_LOCKED;
               w_sel_nxt   = w_pick;
            end
         end
         S_LOCKED: begin
            if (w_push && w_sel_last) begin
               w_state_nxt = S_IDLE;
               w_rr_nxt    = w_sel_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // arbiter state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   // 2-entry BE FIFO; reset flushes any partial packet
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_flit[0] <= '0;
         r_mem_flit[1] <= '0;
         r_mem_last    <= '0;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_count       <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem_flit[r_wr_ptr] <= w_sel_flit;
            r_mem_last[r_wr_ptr] <= w_sel_last;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 2'd1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   // link mux: TDM beat wins and never pops the FIFO
   always_comb begin
      bus.out_flit  = r_mem_flit[r_rd_ptr];
      bus.out_valid = w_be_valid;
      bus.out_last  = w_be_valid && r_mem_last[r_rd_ptr];
      bus.out_tdm   = 1'b0;
      if (bus.tdm_valid) begin
         bus.out_flit  = bus.tdm_flit;
         bus.out_valid = 1'b1;
         bus.out_last  = 1'b0;
         bus.out_tdm   = 1'b1;
      end
   end
endmodule

// File: tb/tb_hybrid_noc_router_output.sv
// Bench for hybrid_noc_router_output: queue-based model checked
// every cycle plus directed scenarios with literal expectations.
module tb_hybrid_noc_router_output;
   localparam int FW = 32;
   localparam int P  = 5;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   hybrid_noc_router_output_if #(.FLIT_WIDTH(FW), .PORTS(P)) bus ();

   hybrid_noc_router_output #(.FLIT_WIDTH(FW), .PORTS(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // model: owner of the output, next priority, and BE flits in flight
   bit             m_locked;
   int             m_sel;
   int             m_rr;
   logic [FW:0]    m_q [$];
   // observation logs
   logic [FW-1:0]  obs_link [$];
   int             obs_push [$];
   int             obs_src [$];
   int             obs_cyc [$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model, then advance the model
   always @(negedge clk) begin
      logic [P-1:0] e_rdy;
      bit psh;
      bit pop;
      if (!rst) begin
         m_locked = 0;
         m_sel    = 0;
         m_rr     = 0;
         m_q.delete();
      end
      e_rdy = '0;
      if (m_locked && m_q.size() < 2) e_rdy = P'(1 << m_sel);
      chk("in_ready", bus.in_ready, e_rdy);
      chk("out_valid", bus.out_valid, bus.tdm_valid || m_q.size() > 0);
      chk("out_tdm", bus.out_tdm, bus.tdm_valid);
      if (bus.tdm_valid) begin
         chk("tdm_flit", bus.out_flit, bus.tdm_flit);
         chk("tdm_last", bus.out_last, 1'b0);
      end else if (m_q.size() > 0) begin
         chk("be_flit", bus.out_flit, m_q[0][FW-1:0]);
         chk("be_last", bus.out_last, m_q[0][FW]);
      end
      if (rst) begin
         if (bus.out_valid && (bus.out_tdm || bus.out_ready))
            obs_link.push_back(bus.out_flit);
         for (int i = 0; i < P; i++) begin
            if (bus.in_valid[i] && bus.in_ready[i]) begin
               obs_push.push_back(i);
               if (bus.in_last[i]) begin
                  obs_src.push_back(i);
                  obs_cyc.push_back(cyc);
               end
            end
         end
         psh = m_locked && bus.in_valid[m_sel] && m_q.size() < 2;
         pop = !bus.tdm_valid && m_q.size() > 0 && bus.out_ready;
         if (pop) void'(m_q.pop_front());
         if (psh) begin
            m_q.push_back({bus.in_last[m_sel], bus.in_flit[m_sel*FW +: FW]});
            if (bus.in_last[m_sel]) begin
               m_locked = 0;
               m_rr     = (m_sel + 1) % P;
            end
         end else if (!m_locked) begin
            for (int k = 0; k < P; k++) begin
               if (bus.in_valid[(m_rr + k) % P]) begin
                  m_locked = 1;
                  m_sel    = (m_rr + k) % P;
                  break;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      obs_link.delete();
      obs_push.delete();
      obs_src.delete();
      obs_cyc.delete();
   endtask

   task automatic send_pkt(input int p, input logic [FW-1:0] base,
                           input int n);
      int   k      = 0;
      int   budget = 0;
      logic hit;
      while (k < n && budget < 100) begin
         bus.in_valid[p]          = 1'b1;
         bus.in_flit[p*FW +: FW] = base + FW'(k);
         bus.in_last[p]           = (k == n - 1);
         #1;
         hit = bus.in_ready[p];
         @(posedge clk);
         #1;
         if (hit) k++;
         budget++;
      end
      bus.in_valid[p] = 1'b0;
      bus.in_last[p]  = 1'b0;
      chk("send_done", 64'(k), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      bus.in_flit   = '0;
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.tdm_flit  = '0;
      bus.tdm_valid = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      chk("rst_in_ready", bus.in_ready, 5'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_last", bus.out_last, 1'b0);
      bus.tdm_valid = 1'b1;
      bus.tdm_flit  = 32'h5A;
      #1;
      chk("rst_tdm_valid", bus.out_valid, 1'b1);
      chk("rst_tdm_flag", bus.out_tdm, 1'b1);
      chk("rst_tdm_flit", bus.out_flit, 32'h5A);
      bus.tdm_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();

      // scenario 1: input 2, 3-flit packet
      clear_logs();
      bus.in_valid = 5'b00100;
      bus.in_flit[2*FW +: FW] = 32'hA0;
      #1 chk("s1_c0_rdy", bus.in_ready, 5'b0);
      tick();
      #1 chk("s1_c1_grant", bus.in_ready, 5'b00100);
      chk("s1_c1_oval", bus.out_valid, 1'b0);
      tick();
      bus.in_flit[2*FW +: FW] = 32'hA1;
      #1 chk("s1_c2_flit", bus.out_flit, 32'hA0);
      chk("s1_c2_last", bus.out_last, 1'b0);
      tick();
      bus.in_flit[2*FW +: FW] = 32'hA2;
      bus.in_last = 5'b00100;
      #1 chk("s1_c3_flit", bus.out_flit, 32'hA1);
      tick();
      bus.in_valid = '0;
      bus.in_last  = '0;
      #1 chk("s1_c4_flit", bus.out_flit, 32'hA2);
      chk("s1_c4_last", bus.out_last, 1'b1);
      chk("s1_c4_rdy", bus.in_ready, 5'b0);
      tick();
      #1 chk("s1_c5_oval", bus.out_valid, 1'b0);
      tick();
      chk("s1_npush", obs_push.size(), 3);

      // scenario 2: 0, 3, 4 compete with rr_ptr at 3
      clear_logs();
      fork
         send_pkt(0, 32'hC0, 1);
         send_pkt(3, 32'hC3, 1);
         send_pkt(4, 32'hC4, 1);
      join
      repeat (3) tick();
      chk("s2_npkt", obs_src.size(), 3);
      chk("s2_npush", obs_push.size(), 3);
      if (obs_src.size() == 3) begin
         chk("s2_first", obs_src[0], 3);
         chk("s2_second", obs_src[1], 4);
         chk("s2_third", obs_src[2], 0);
         chk("s2_gap1", obs_cyc[1] - obs_cyc[0], 2);
         chk("s2_gap2", obs_cyc[2] - obs_cyc[1], 2);
      end
      chk("s2_nlink", obs_link.size(), 3);
      if (obs_link.size() == 3) begin
         chk("s2_link0", obs_link[0], 32'hC3);
         chk("s2_link1", obs_link[1], 32'hC4);
         chk("s2_link2", obs_link[2], 32'hC0);
      end

      // scenario 3: backpressure on a 4-flit packet
      clear_logs();
      bus.out_ready = 1'b0;
      fork
         send_pkt(1, 32'hD0, 4);
         begin
            repeat (6) tick();
            chk("s3_full_rdy", bus.in_ready, 5'b0);
            chk("s3_accepted", obs_push.size(), 2);
            chk("s3_head", bus.out_flit, 32'hD0);
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) tick();
      chk("s3_nlink", obs_link.size(), 4);
      if (obs_link.size() == 4) begin
         chk("s3_link0", obs_link[0], 32'hD0);
         chk("s3_link1", obs_link[1], 32'hD1);
         chk("s3_link2", obs_link[2], 32'hD2);
         chk("s3_link3", obs_link[3], 32'hD3);
      end

      // scenario 4: TDM beat while 0xB1 is at the head
      clear_logs();
      fork
         send_pkt(0, 32'hB0, 4);
         begin
            int w     = 0;
            bit found = 0;
            while (!found && w < 30) begin
               @(posedge clk);
               #2;
               if (bus.out_valid && !bus.out_tdm && bus.out_flit == 32'hB1)
                  found = 1;
               w++;
            end
            chk("s4_found", found, 1'b1);
            if (found) begin
               bus.tdm_valid = 1'b1;
               bus.tdm_flit  = 32'hCC;
               #1 chk("s4_tdm_flit", bus.out_flit, 32'hCC);
               chk("s4_tdm_flag", bus.out_tdm, 1'b1);
               @(posedge clk);
               #1 bus.tdm_valid = 1'b0;
               #1 chk("s4_after", bus.out_flit, 32'hB1);
               chk("s4_after_be", bus.out_tdm, 1'b0);
            end
         end
      join
      repeat (4) tick();
      chk("s4_nlink", obs_link.size(), 5);
      if (obs_link.size() == 5) begin
         chk("s4_link0", obs_link[0], 32'hB0);
         chk("s4_link1", obs_link[1], 32'hCC);
         chk("s4_link2", obs_link[2], 32'hB1);
         chk("s4_link3", obs_link[3], 32'hB2);
         chk("s4_link4", obs_link[4], 32'hB3);
      end

      // scenario 5: stalled packet held, then reset mid-packet
      clear_logs();
      bus.out_ready = 1'b0;
      bus.in_valid  = 5'b10000;
      bus.in_flit[4*FW +: FW] = 32'hE0;
      tick();
      #1 chk("s5_grant4", bus.in_ready, 5'b10000);
      tick();
      bus.in_valid = 5'b00001;
      bus.in_last  = 5'b00001;
      bus.in_flit[0 +: FW] = 32'hF0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("s5_lock_held", bus.in_ready, 5'b10000);
         tick();
      end
      chk("s5_pre_oval", bus.out_valid, 1'b1);
      rst = 1'b0;
      #1 chk("s5_rst_rdy", bus.in_ready, 5'b0);
      chk("s5_rst_oval", bus.out_valid, 1'b0);
      chk("s5_rst_tdm", bus.out_tdm, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1 chk("s5_idle_rdy", bus.in_ready, 5'b0);
      tick();
      #1 chk("s5_regrant", bus.in_ready, 5'b00001);
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = '0;
      bus.in_last  = '0;
      repeat (3) tick();
      chk("s5_nlink", obs_link.size(), 1);
      if (obs_link.size() == 1) chk("s5_link0", obs_link[0], 32'hF0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hybrid_noc_router_output.md
# hybrid_noc_router_output

Output port of the hybrid NoC router and counterpart to the router input port. Collects best-effort (BE) packets from all input ports, each presenting a flit with a one-hot valid toward this output. Grants one input at a time for a whole packet (wormhole, round-robin between packets) and buffers BE flits in a 2-entry FIFO. Time-division-multiplexed (TDM) flits, forwarded directly from the TDM path, take priority on the link.

## Interface

- FLIT_WIDTH, 'x, flit width in bits
- PORTS, 'x, number of router input ports competing for this output (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- in_flit  in  PORTS*FLIT_WIDTH  BE flit from each input; slice i = input i
- in_valid  in  PORTS  bit i: input i requests this output with a valid flit
- in_last  in  PORTS  bit i: flit from input i is the packet's last flit
- in_ready  out  PORTS  bit i: this output accepts input i's flit this cycle
- tdm_flit  in  FLIT_WIDTH  TDM flit for this output
- tdm_valid  in  1  TDM flit present; no backpressure
- out_flit  out  FLIT_WIDTH  link flit
- out_valid  out  1  link flit valid
- out_last  out  1  last flit of BE packet (0 for TDM beats)
- out_tdm  out  1  current beat is TDM
- out_ready  in  1  downstream BE ready; ignored for TDM beats

## Operation

- Arbiter FSM, states IDLE and LOCKED; registers sel (input index) and rr_ptr (next priority index), both width clog2(PORTS) (min 1).
- IDLE: in_ready = 0. If any in_valid bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, … modulo PORTS. Register it into sel and enter LOCKED next cycle.
- LOCKED: in_ready[sel] = (count < 2); all other in_ready bits are 0. A push occurs on in_valid[sel] && in_ready[sel]. Push writes in_flit slice sel and in_last[sel] into the FIFO.
- Push with in_last[sel]=1: next state IDLE, rr_ptr ← (sel+1) mod PORTS.
- in_valid[sel] may drop mid-packet. The lock holds indefinitely until the last flit is pushed.
- Requests from non-selected inputs are ignored while LOCKED; no flit from them enters the FIFO.
- FIFO: 2 entries of {flit, last}, with a 2-bit count.
  - Push and pop may happen in the same cycle.
  - No push when full: in_ready is computed from the registered count, so there is no pass-through.
- Link mux (combinational):
  - tdm_valid=1: out_flit=tdm_flit, out_valid=1, out_tdm=1, out_last=0, no pop.
  - Otherwise: out_flit/out_last = FIFO head, out_valid = (count≠0), out_tdm=0. Pop on out_valid && out_ready.
- TDM beats never consume out_ready and are never dropped. BE flits are never dropped or reordered.

## Timing

- Reset (rst=0): state IDLE, rr_ptr=0, sel=0, count=0, in_ready=0.
  - out_valid=tdm_valid, out_tdm=tdm_valid, out_last=0.
  - out_flit=tdm_flit if tdm_valid, else don't-care.
- Reset mid-packet flushes the FIFO and releases the lock. The upstream input must also be reset.
- Arbitration: request seen in cycle n (IDLE) → in_ready[sel] may assert in cycle n+1.
- Packets are separated by one IDLE bubble.
- BE latency: flit pushed in cycle n appears on out_* in cycle n+1 at the earliest (no TDM, FIFO was empty).
- Sustained BE throughput is 1 flit/cycle with out_ready=1 and tdm_valid=0, except the per-packet bubble.
- TDM latency is zero cycles (combinational).
- Continuous tdm_valid starves BE. The FIFO fills to 2, then in_ready[sel]=0 until TDM gaps appear.

## Test plan

- FLIT_WIDTH=32, PORTS=5. Input 2 sends a 3-flit packet 0xA0,0xA1,0xA2 with out_ready=1.
  - Required: grant in cycle 1, pushes in cycles 1-3.
  - Required: out_valid cycles 2-4 with flits in order, out_last only on 0xA2, then rr_ptr=3.
- Inputs 0, 3 and 4 request simultaneously with 1-flit packets, rr_ptr=3.
  - Required: service order 3, 4, 0, each separated by one IDLE cycle.
  - Required: in_ready never asserted for a non-selected input.
- Input 1 sends 4 flits with out_ready=0.
  - Required: the FIFO accepts 2 flits, then in_ready[1]=0.
  - Required: after out_ready=1, all 4 flits emerge in order with no loss or duplication.
- TDM interleave: input 0 streams 0xB0-0xB3, and tdm_valid=1 with 0xCC in the cycle where 0xB1 is at the FIFO head.
  - Required: link shows 0xCC with out_tdm=1, then 0xB1. The order of the BE flits is unchanged.
- Mid-packet stall and reset:
  - Input 4 pushes 1 of 3 flits, then in_valid[4]=0 for 5 cycles while input 0 requests. Required: lock held, in_ready[0]=0 throughout.
  - Then assert rst=0. Required: count=0, in_ready=0, out_valid=0 (tdm_valid=0), IDLE.
